zfifo_ex: RTL and testbench



---
 rtl/zfifo_ex.sv | 162 ++++++++++++++++
 tb/tb_zfifo_ex.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/zfifo_ex.sv
// zfifo_ex: parametrised single-clock synchronous FIFO with fill-level count,
// programmable almost-full / almost-empty thresholds and sticky
// overflow / underflow flags.
//
// Build option:
//   ZFIFO_FWFT_EN  first-word-fall-through read mode. oData presents the head
//                  word whenever oEmpty=0 and iRdEn pops it. When undefined,
//                  oData is loaded on the edge that accepts a read.
//
// Ports:
//   iClk, iRstN    clock (rising edge), asynchronous active-low reset
//   iWrEn, iData   write request and write data
//   oFull          count == DEPTH
//   oAlmostFull    count >= AF_LEVEL
//   iRdEn, oData   read request and read data
//   oEmpty         count == 0
//   oAlmostEmpty   count <= AE_LEVEL
//   oCount         number of stored words, 0..DEPTH
//   iClrErr        synchronous clear of the sticky error flags
//   oOverflow      sticky: a write was rejected
//   oUnderflow     sticky: a read was rejected
//
// All outputs are registered; status flags are computed from the next count.

module zfifo_ex #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned DEPTH      = 64,
    parameter int unsigned LOG2_DEPTH = 6,
    parameter int unsigned AF_LEVEL   = 60,
    parameter int unsigned AE_LEVEL   = 4
) (
    input  logic                  iClk,
    input  logic                  iRstN,
    input  logic                  iWrEn,
    input  logic [WIDTH-1:0]      iData,
    output logic                  oFull,
    output logic                  oAlmostFull,
    input  logic                  iRdEn,
    output logic [WIDTH-1:0]      oData,
    output logic                  oEmpty,
    output logic                  oAlmostEmpty,
    output logic [LOG2_DEPTH:0]   oCount,
    input  logic                  iClrErr,
    output logic                  oOverflow,
    output logic                  oUnderflow
);

    localparam int unsigned PW = LOG2_DEPTH;
    localparam int unsigned CW = LOG2_DEPTH + 1;

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_CNT   = CW'(AE_LEVEL);
    localparam logic [CW-1:0] ONE_CNT  = CW'(1);

    // Storage; contents are deliberately not reset.
    logic [WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    logic          wr_acc_c;
    logic          rd_acc_c;
    logic [PW-1:0] wr_ptr_inc_c;
    logic [PW-1:0] rd_ptr_inc_c;
    logic [CW-1:0] count_nxt_c;
    logic          ovf_set_c;
    logic          udf_set_c;
    logic          data_load_c;
    logic [WIDTH-1:0] data_nxt_c;

    // Acceptance: a read frees a slot, so a full FIFO still accepts a write
    // in the same cycle; an empty FIFO never accepts a read.
    always_comb begin
        rd_acc_c     = iRdEn & ~oEmpty;
        wr_acc_c     = iWrEn & (~oFull | rd_acc_c);
        ovf_set_c    = iWrEn & ~wr_acc_c;
        udf_set_c    = iRdEn & ~rd_acc_c;
        wr_ptr_inc_c = wr_ptr + PW'(1);
        rd_ptr_inc_c = rd_ptr + PW'(1);
    end

    // Next fill level.
    always_comb begin
        count_nxt_c = oCount;
        case ({wr_acc_c, rd_acc_c})
            2'b10:   count_nxt_c = oCount + ONE_CNT;
            2'b01:   count_nxt_c = oCount - ONE_CNT;
            default: count_nxt_c = oCount;
        endcase
    end

`ifdef ZFIFO_FWFT_EN
    // Head-word register. After a pop the new head is the next stored word,
    // unless only one word was left, in which case it is the word being
    // written this cycle (if none is written the FIFO goes empty and oData
    // is a don't-care). A write into an empty FIFO falls straight through.
    always_comb begin
        data_load_c = 1'b0;
        data_nxt_c  = oData;
        if (rd_acc_c) begin
            data_load_c = 1'b1;
            if (oCount == ONE_CNT) begin
                data_nxt_c = iData;
            end else begin
                data_nxt_c = mem[rd_ptr_inc_c];
            end
        end else if (oEmpty && wr_acc_c) begin
            data_load_c = 1'b1;
            data_nxt_c  = iData;
        end
    end
`else
    // Standard mode: the word is fetched on the edge that accepts the read.
    always_comb begin
        data_load_c = rd_acc_c;
        data_nxt_c  = mem[rd_ptr];
    end
`endif

    // Memory write port.
    always_ff @(posedge iClk) begin
        if (wr_acc_c) begin
            mem[wr_ptr] <= iData;
        end
    end

    // Pointers, count, status flags and read data.
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            oCount       <= '0;
            oEmpty       <= 1'b1;
            oAlmostEmpty <= 1'b1;
            oFull        <= 1'b0;
            oAlmostFull  <= 1'b0;
            oData        <= '0;
            oOverflow    <= 1'b0;
            oUnderflow   <= 1'b0;
        end else begin
            if (wr_acc_c) begin
                wr_ptr <= wr_ptr_inc_c;
            end
            if (rd_acc_c) begin
                rd_ptr <= rd_ptr_inc_c;
            end
            if (data_load_c) begin
                oData <= data_nxt_c;
            end
            oCount       <= count_nxt_c;
            oEmpty       <= (count_nxt_c == '0);
            oAlmostEmpty <= (count_nxt_c <= AE_CNT);
            oFull        <= (count_nxt_c == FULL_CNT);
            oAlmostFull  <= (count_nxt_c >= AF_CNT);
            // A new error in the clearing cycle wins over the clear.
            oOverflow    <= ovf_set_c | (oOverflow & ~iClrErr);
            oUnderflow   <= udf_set_c | (oUnderflow & ~iClrErr);
        end
    end

endmodule

// File: tb/tb_zfifo_ex.sv
// Directed bench for zfifo_ex (DEPTH=64, WIDTH=8, AF_LEVEL=60, AE_LEVEL=4).
module tb_zfifo_ex;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 64;
    localparam int unsigned LOG2  = 6;

    logic             iClk = 1'b0;
    logic             iRstN = 1'b1;
    logic             iWrEn = 1'b0;
    logic [WIDTH-1:0] iData = '0;
    logic             iRdEn = 1'b0;
    logic             iClrErr = 1'b0;
    logic             oFull, oAlmostFull, oEmpty, oAlmostEmpty;
    logic             oOverflow, oUnderflow;
    logic [WIDTH-1:0] oData;
    logic [LOG2:0]    oCount;

    int errors = 0;
    int checks = 0;

    zfifo_ex #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .LOG2_DEPTH(LOG2),
        .AF_LEVEL(60), .AE_LEVEL(4)
    ) dut (
        .iClk(iClk), .iRstN(iRstN),
        .iWrEn(iWrEn), .iData(iData), .oFull(oFull), .oAlmostFull(oAlmostFull),
        .iRdEn(iRdEn), .oData(oData), .oEmpty(oEmpty), .oAlmostEmpty(oAlmostEmpty),
        .oCount(oCount), .iClrErr(iClrErr),
        .oOverflow(oOverflow), .oUnderflow(oUnderflow)
    );

    always #5 iClk = ~iClk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 ns after it.
    task automatic step();
        @(posedge iClk);
        #1;
    endtask

    task automatic check_flags(input string tag, input int cnt, input logic ovf, input logic udf);
        check({tag, ".count"}, 32'(oCount), 32'(cnt));
        check({tag, ".empty"}, 32'(oEmpty), 32'(cnt == 0));
        check({tag, ".full"}, 32'(oFull), 32'(cnt == 64));
        check({tag, ".afull"}, 32'(oAlmostFull), 32'(cnt >= 60));
        check({tag, ".aempty"}, 32'(oAlmostEmpty), 32'(cnt <= 4));
        check({tag, ".ovf"}, 32'(oOverflow), 32'(ovf));
        check({tag, ".udf"}, 32'(oUnderflow), 32'(udf));
    endtask

    task automatic clear_errors();
        iClrErr = 1'b1;
        step();
        iClrErr = 1'b0;
    endtask

    initial begin
        logic [WIDTH-1:0] q [$];
        logic [WIDTH-1:0] exp_d;
        int               cnt;
        logic             wr, rd;

        #2 iRstN = 1'b0;
        step();
        step();
        check_flags("reset", 0, 1'b0, 1'b0);
        check("reset.data", 32'(oData), 32'h0);
        iRstN = 1'b1;

`ifdef ZFIFO_FWFT_EN
        // Write to empty falls through with no read request.
        iWrEn = 1'b1; iData = 8'h3C;
        step();
        iWrEn = 1'b0;
        check("fwft.data", 32'(oData), 32'h3C);
        check_flags("fwft.one", 1, 1'b0, 1'b0);
        iRdEn = 1'b1;
        step();
        iRdEn = 1'b0;
        check_flags("fwft.pop", 0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            iWrEn = 1'b1; iData = 8'(8'hA1 + i);
            step();
        end
        iWrEn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("fwft.head", 32'(oData), 32'(8'hA1 + i));
            check("fwft.cnt", 32'(oCount), 32'(3 - i));
            iRdEn = 1'b1;
            step();
            iRdEn = 1'b0;
        end
        check_flags("fwft.drained", 0, 1'b0, 1'b0);
`else
        // Fill 0..63 then one rejected write.
        for (int i = 0; i < 64; i++) begin
            iWrEn = 1'b1; iData = 8'(i);
            step();
            check("fill.count", 32'(oCount), 32'(i + 1));
            check("fill.afull", 32'(oAlmostFull), 32'(i + 1 >= 60));
            check("fill.full", 32'(oFull), 32'(i == 63));
        end
        iData = 8'hFF;
        step();
        iWrEn = 1'b0;
        check_flags("overflow", 64, 1'b1, 1'b0);

        // Drain from full; data 0..63, rejected 0xFF never appears.
        for (int i = 0; i < 64; i++) begin
            iRdEn = 1'b1;
            step();
            check("drain.data", 32'(oData), 32'(i));
            check("drain.count", 32'(oCount), 32'(63 - i));
            check("drain.aempty", 32'(oAlmostEmpty), 32'(63 - i <= 4));
            check("drain.empty", 32'(oEmpty), 32'(i == 63));
        end
        step();
        iRdEn = 1'b0;
        check_flags("underflow", 0, 1'b1, 1'b1);
        check("underflow.hold", 32'(oData), 32'd63);
        clear_errors();
        check_flags("clrerr", 0, 1'b0, 1'b0);

        // Simultaneous write and read while full.
        for (int i = 0; i < 64; i++) begin
            iWrEn = 1'b1; iData = 8'(100 + i);
            step();
        end
        iRdEn = 1'b1; iData = 8'hAA;
        step();
        iWrEn = 1'b0;
        check("simfull.data", 32'(oData), 32'd100);
        check_flags("simfull", 64, 1'b0, 1'b0);
        for (int i = 0; i < 64; i++) begin
            step();
            exp_d = (i < 63) ? 8'(101 + i) : 8'hAA;
            check("simfull.drain", 32'(oData), 32'(exp_d));
        end
        iRdEn = 1'b0;
        check_flags("simfull.end", 0, 1'b0, 1'b0);

        // Simultaneous write and read while empty: write only.
        iWrEn = 1'b1; iRdEn = 1'b1; iData = 8'h77;
        step();
        iWrEn = 1'b0;
        check_flags("simempty", 1, 1'b0, 1'b1);
        step();
        iRdEn = 1'b0;
        check("simempty.data", 32'(oData), 32'h77);
        check_flags("simempty.end", 0, 1'b0, 1'b1);
        clear_errors();

        // Interleaved traffic holding the level between 10 and 20.
        for (int i = 0; i < 15; i++) begin
            iWrEn = 1'b1; iData = 8'(8'hC0 + i);
            q.push_back(8'(8'hC0 + i));
            step();
        end
        iWrEn = 1'b0;
        for (int i = 0; i < 200; i++) begin
            cnt = q.size();
            wr = ((i % 4) != 3) && (cnt < 20);
            rd = ((i % 4) != 0) && (cnt > 10);
            iWrEn = wr; iRdEn = rd; iData = 8'(i) ^ 8'h5C;
            exp_d = '0;
            if (rd) exp_d = q.pop_front();
            if (wr) q.push_back(8'(i) ^ 8'h5C);
            step();
            if (rd) check("wrap.data", 32'(oData), 32'(exp_d));
            check("wrap.count", 32'(oCount), 32'(q.size()));
        end
        iWrEn = 1'b0;
        iRdEn = 1'b0;
        check("wrap.ovf", 32'(oOverflow), 32'h0);
        check("wrap.udf", 32'(oUnderflow), 32'h0);
        while (q.size() > 0) begin
            exp_d = q.pop_front();
            iRdEn = 1'b1;
            step();
            check("wrap.drain", 32'(oData), 32'(exp_d));
        end
        iRdEn = 1'b0;
        check_flags("wrap.end", 0, 1'b0, 1'b0);

        // Reset mid-operation at count 30.
        for (int i = 0; i < 30; i++) begin
            iWrEn = 1'b1; iData = 8'(i + 1);
            step();
        end
        iWrEn = 1'b0;
        check("prereset.count", 32'(oCount), 32'd30);
        iRstN = 1'b0;
        #2;
        check_flags("midreset", 0, 1'b0, 1'b0);
        check("midreset.data", 32'(oData), 32'h0);
        step();
        iRstN = 1'b1;
        iWrEn = 1'b1; iData = 8'h5A;
        step();
        iWrEn = 1'b0; iRdEn = 1'b1;
        step();
        iRdEn = 1'b0;
        check("postreset.data", 32'(oData), 32'h5A);
        check_flags("postreset", 0, 1'b0, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
